// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: control, instruction-memory and decode-side signals of the fetch stage.
interface instruction_fetch_if;
    logic       start;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halt_req;
    logic [7:0] q;
    logic [7:0] address;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       halted;

    modport slave (
        input  start, stall, redirect, redirect_pc, halt_req, q,
        output address, instr, instr_pc, instr_valid, halted
    );

    modport master (
        output start, stall, redirect, redirect_pc, halt_req, q,
        input  address, instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, reads instruction memory and fills the instruction register.
// Define IFETCH_HALT_DETECT_EN to stop fetching when a HALT_OPCODE byte is fetched.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'h00
) (
    input logic                Clock,
    input logic                Resetn,
    instruction_fetch_if.slave bus
);
`ifdef IFETCH_HALT_DETECT_EN
    localparam bit HALT_DETECT = 1'b1;
`else
    localparam bit HALT_DETECT = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
    logic       instr_valid_q, instr_valid_d, halted_q, halted_d;
    logic       halt_hit;
    assign halt_hit = HALT_DETECT && bus.q == HALT_OPCODE;
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        if (state_q == IDLE) begin
            state_d = bus.start ? RUN : IDLE;
        end else if (state_q == HALT) begin
            if (bus.start) begin
                state_d = RUN;
                pc_d    = RESET_PC;
            end
        end else if (bus.halt_req) begin
            state_d       = HALT;
            instr_valid_d = 1'b0;
        end else if (bus.redirect) begin
            pc_d          = bus.redirect_pc;
            instr_valid_d = 1'b0;
        end else if (!bus.stall) begin
            // a detected HALT byte is swallowed: PC stays on it, nothing issues
            if (halt_hit) begin
                state_d       = HALT;
                instr_valid_d = 1'b0;
            end else begin
                instr_d       = bus.q;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                pc_d          = pc_q + 8'd1;
            end
        end
        halted_d = state_d == HALT;
    end
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 8'h00;
            instr_pc_q    <= 8'h00;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end
    assign bus.address     = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.halted      = halted_q;
endmodule
